// File: rtl/remote_calc_core_if.sv
// Bus bundle for remote_calc_core: UART rx/tx byte streams, keypad strobes and status.
// slave = calculator core side, master = surrounding UART/keypad/display side.
interface remote_calc_core_if #(
  parameter int unsigned WIDTH = 8
);
  logic [7:0]       rxdData;
  logic             rxdDataReady;
  logic [3:0]       num;
  logic             numPressed;
  logic [1:0]       opt;
  logic             optPressed;
  logic             clear;
  logic             submit;
  logic             txdBusy;
  logic             txdStart;
  logic [7:0]       txdData;
  logic [WIDTH-1:0] numA;
  logic [WIDTH-1:0] numB;
  logic             sign;
  logic             clcZero;
  logic             error;
  logic             busy;

  modport slave (
    input  rxdData, rxdDataReady, num, numPressed, opt, optPressed,
           clear, submit, txdBusy,
    output txdStart, txdData, numA, numB, sign, clcZero, error, busy
  );

  modport master (
    output rxdData, rxdDataReady, num, numPressed, opt, optPressed,
           clear, submit, txdBusy,
    input  txdStart, txdData, numA, numB, sign, clcZero, error, busy
  );
endinterface

// File: rtl/remote_calc_core.sv
// Remote calculator core: decimal A from UART, op/B from keypad, signed decimal reply over UART.
// Define CALC_MUL_EN to build the sequential shift-add multiplier for op 3.
module remote_calc_core #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 5
) (
  input  logic               clk,
  input  logic               reset,
  remote_calc_core_if.slave  bus
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned AW = WIDTH + 4;
  localparam int unsigned CW = $clog2(W2 + 1);
  localparam int unsigned PW = $clog2(DIGITS + 2);
  localparam int unsigned BW = 4 * DIGITS;
`ifdef CALC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_GET_A,
    S_GET_OP,
    S_GET_B,
    S_CALC,
    S_CONV,
    S_SEND_WAIT,
    S_SEND_PULSE,
    S_SEND_GUARD,
    S_RELEASE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_a_ovf;
  logic             r_b_ovf;
  logic [1:0]       r_op;
  logic             r_sign;
  logic             r_zero;
  logic             r_error;
  logic             r_err_path;
  logic [W2-1:0]    r_mag;
  logic [BW-1:0]    r_bcd;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_ptr;
  logic             r_txd_start;
  logic [7:0]       r_txd_data;
`ifdef CALC_MUL_EN
  logic [W2-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [W2-1:0]    w_mul_sum;
`endif

  logic             w_rx_digit;
  logic             w_rx_cr;
  logic             w_key_digit;
  logic [AW-1:0]    w_a_prod;
  logic [AW-1:0]    w_b_prod;
  logic             w_a_ovf;
  logic             w_b_ovf;
  logic             w_op_err;
  logic [WIDTH-1:0] w_diff;
  logic             w_conv_last;
  logic [BW-1:0]    w_bcd_adj;
  logic [BW-1:0]    w_bcd_shift;
  logic [W2-1:0]    w_mag_shift;
  logic [3:0]       w_digit;
  logic [PW-1:0]    w_msd;
  logic [PW-1:0]    w_ptr_next;
  logic [7:0]       w_byte;
  logic             w_last;
  logic             w_skip_sign;

  always_comb begin
    w_rx_digit  = bus.rxdDataReady && (bus.rxdData >= 8'h30) && (bus.rxdData <= 8'h39);
    w_rx_cr     = bus.rxdDataReady && (bus.rxdData == 8'h0D);
    w_key_digit = bus.numPressed && (bus.num <= 4'd9);
    w_a_prod    = AW'(r_a) * AW'(10) + AW'(bus.rxdData[3:0]);
    w_b_prod    = AW'(r_b) * AW'(10) + AW'(bus.num);
    w_a_ovf     = |w_a_prod[AW-1:WIDTH];
    w_b_ovf     = |w_b_prod[AW-1:WIDTH];
    w_diff      = (r_b > r_a) ? (r_b - r_a) : (r_a - r_b);
    w_op_err    = r_a_ovf || r_b_ovf || (r_op == 2'd0) || ((r_op == 2'd3) && !MUL_EN);
    w_conv_last = (r_cnt == CW'(W2 - 1));
`ifdef CALC_MUL_EN
    w_mul_sum   = r_mag + (r_mplier[0] ? r_mcand : '0);
`endif

    // Double-dabble step: add 3 to every digit >= 5, then shift the magnitude MSB in.
    w_bcd_adj = r_bcd;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_bcd_shift = {w_bcd_adj[BW-2:0], r_mag[W2-1]};
    w_mag_shift = {r_mag[W2-2:0], 1'b0};

    // r_ptr: 0 = sign slot, 1..DIGITS = digits MSD first, DIGITS+1 = CR.
    w_digit = 4'd0;
    w_msd   = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_ptr == PW'(DIGITS - i)) w_digit = r_bcd[4*i +: 4];
      if (r_bcd[4*i +: 4] != 4'd0) w_msd = PW'(i);
    end
    w_ptr_next  = (!r_err_path && (r_ptr == '0)) ? (PW'(DIGITS) - w_msd) : (r_ptr + 1'b1);
    w_skip_sign = !r_err_path && (r_ptr == '0) && !r_sign;

    if (r_err_path) begin
      w_byte = (r_ptr == PW'(2)) ? 8'h0D : 8'h45;
      w_last = (r_ptr == PW'(2));
    end else begin
      w_last = (r_ptr == PW'(DIGITS + 1));
      if (r_ptr == '0)  w_byte = 8'h2D;
      else if (w_last)  w_byte = 8'h0D;
      else              w_byte = {4'h3, w_digit};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_GET_A:      if (!bus.clear && w_rx_cr) w_state_nxt = S_GET_OP;
      S_GET_OP:     if (!bus.clear && bus.optPressed) w_state_nxt = S_GET_B;
      S_GET_B: begin
        if (bus.clear)       w_state_nxt = S_GET_OP;
        else if (bus.submit) w_state_nxt = S_CALC;
      end
      S_CALC: begin
        if (w_op_err)                           w_state_nxt = S_SEND_WAIT;
        else if (r_op != 2'd3)                  w_state_nxt = S_CONV;
        else if (r_cnt == CW'(WIDTH))           w_state_nxt = S_CONV;
      end
      S_CONV:       if (w_conv_last) w_state_nxt = S_SEND_WAIT;
      S_SEND_WAIT:  if (!w_skip_sign && !bus.txdBusy) w_state_nxt = S_SEND_PULSE;
      S_SEND_PULSE: w_state_nxt = S_SEND_GUARD;
      S_SEND_GUARD: w_state_nxt = w_last ? S_RELEASE : S_SEND_WAIT;
      S_RELEASE:    if (!bus.submit) w_state_nxt = S_GET_A;
      default:      w_state_nxt = S_GET_A;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_GET_A;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_a_ovf     <= 1'b0;
      r_b_ovf     <= 1'b0;
      r_op        <= '0;
      r_sign      <= 1'b0;
      r_zero      <= 1'b0;
      r_error     <= 1'b0;
      r_err_path  <= 1'b0;
      r_mag       <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_txd_start <= 1'b0;
      r_txd_data  <= '0;
`ifdef CALC_MUL_EN
      r_mcand     <= '0;
      r_mplier    <= '0;
`endif
    end else begin
      case (r_state)
        S_GET_A: begin
          if (bus.clear) begin
            r_a     <= '0;
            r_a_ovf <= 1'b0;
          end else if (w_rx_digit) begin
            if (w_a_ovf) r_a_ovf <= 1'b1;
            else         r_a     <= w_a_prod[WIDTH-1:0];
          end
        end
        S_GET_OP: begin
          if (bus.clear) begin
            r_op    <= '0;
            r_b     <= '0;
            r_b_ovf <= 1'b0;
          end else if (bus.optPressed) begin
            r_op    <= bus.opt;
            r_b     <= '0;
            r_b_ovf <= 1'b0;
          end
        end
        S_GET_B: begin
          if (bus.clear) begin
            r_op    <= '0;
            r_b     <= '0;
            r_b_ovf <= 1'b0;
          end else begin
            if (w_key_digit) begin
              if (w_b_ovf) r_b_ovf <= 1'b1;
              else         r_b     <= w_b_prod[WIDTH-1:0];
            end
            if (bus.optPressed) r_op <= bus.opt;
          end
        end
        S_CALC: begin
          r_ptr <= '0;
          r_bcd <= '0;
          if (w_op_err) begin
            r_error    <= 1'b1;
            r_err_path <= 1'b1;
            r_sign     <= 1'b0;
            r_zero     <= 1'b0;
          end else begin
            r_error    <= 1'b0;
            r_err_path <= 1'b0;
            case (r_op)
              2'd1: begin
                r_mag  <= W2'(r_a) + W2'(r_b);
                r_sign <= 1'b0;
                r_zero <= (r_a == '0) && (r_b == '0);
              end
              2'd2: begin
                r_mag  <= W2'(w_diff);
                r_sign <= (r_b > r_a);
                r_zero <= (r_a == r_b);
              end
`ifdef CALC_MUL_EN
              2'd3: begin
                r_sign <= 1'b0;
                if (r_cnt == '0) begin
                  r_mcand  <= W2'(r_a);
                  r_mplier <= r_b;
                  r_mag    <= '0;
                  r_cnt    <= CW'(1);
                end else begin
                  r_mag    <= w_mul_sum;
                  r_mcand  <= r_mcand << 1;
                  r_mplier <= r_mplier >> 1;
                  if (r_cnt == CW'(WIDTH)) begin
                    r_zero <= (w_mul_sum == '0);
                    r_cnt  <= '0;
                  end else begin
                    r_cnt  <= r_cnt + 1'b1;
                  end
                end
              end
`endif
              default: ;
            endcase
          end
        end
        S_CONV: begin
          r_bcd <= w_bcd_shift;
          r_mag <= w_mag_shift;
          r_cnt <= w_conv_last ? '0 : (r_cnt + 1'b1);
        end
        S_SEND_WAIT: begin
          if (w_skip_sign) begin
            r_ptr <= w_ptr_next;
          end else if (!bus.txdBusy) begin
            r_txd_start <= 1'b1;
            r_txd_data  <= w_byte;
          end
        end
        S_SEND_PULSE: r_txd_start <= 1'b0;
        S_SEND_GUARD: r_ptr <= w_ptr_next;
        S_RELEASE: begin
          r_txd_data <= '0;
          if (!bus.submit) begin
            r_a     <= '0;
            r_a_ovf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.txdStart = r_txd_start;
  assign bus.txdData  = r_txd_data;
  assign bus.numA     = r_a;
  assign bus.numB     = r_b;
  assign bus.sign     = r_sign;
  assign bus.clcZero  = r_zero;
  assign bus.error    = r_error;
  assign bus.busy     = (r_state inside {S_CALC, S_CONV, S_SEND_WAIT, S_SEND_PULSE,
                                         S_SEND_GUARD, S_RELEASE});

endmodule
